lsu: RTL and testbench

//  Load/store unit sitting directly upstream of the DPI-backed data memory stage (mem).

---
 rtl/lsu.sv | 231 +++++++++++++++++++++++
 tb/tb_lsu.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit between EX and the data memory stage
// Decodes size/alignment at acceptance, drives one mem beat, extends load data for WB.
module lsu #(
    parameter int XLEN    = 64,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_is_load_i,
    input  logic            req_is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      rd_i,
    output logic            mem_ren_o,
    output logic [XLEN-1:0] mem_raddr_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            mem_wen_o,
    output logic [XLEN-1:0] mem_waddr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [7:0]      mem_mask_o,
    output logic            resp_valid_o,
    output logic [4:0]      resp_rd_o,
    output logic [XLEN-1:0] resp_data_o,
    output logic            fault_o,
    output logic            hold_flag_o
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_load_q, is_load_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [2:0]      off_q, off_d;
    logic [4:0]      rd_q, rd_d;

    logic            ready_q, ready_d;
    logic            ren_q, ren_d;
    logic [XLEN-1:0] raddr_q, raddr_d;
    logic            wen_q, wen_d;
    logic [XLEN-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [7:0]      mask_q, mask_d;
    logic            resp_valid_q, resp_valid_d;
    logic [4:0]      resp_rd_q, resp_rd_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic            fault_q, fault_d;
    logic            hold_q, hold_d;

    logic            acc_load;
    logic            acc_fault;
    logic            acc_misaligned;
    logic [7:0]      acc_size_mask;
    logic [XLEN-1:0] ld_shifted;
    logic [XLEN-1:0] ld_ext;

    // Load wins when EX flags both load and store.
    assign acc_load = req_is_load_i;

    always_comb begin
        acc_misaligned = 1'b0;
        acc_size_mask  = 8'h00;
        case (funct3_i[1:0])
            2'd0: acc_size_mask = 8'h01;
            2'd1: begin
                acc_size_mask  = 8'h03;
                acc_misaligned = addr_i[0];
            end
            2'd2: begin
                acc_size_mask  = 8'h0F;
                acc_misaligned = |addr_i[1:0];
            end
            default: begin
                acc_size_mask  = 8'hFF;
                acc_misaligned = |addr_i[2:0];
            end
        endcase
        if (acc_load) begin
            acc_fault = acc_misaligned | (funct3_i == 3'b111);
        end else begin
            acc_fault = acc_misaligned | funct3_i[2];
        end
    end

    always_comb begin
        ld_shifted = mem_rdata_i >> {off_q, 3'b000};
        ld_ext     = ld_shifted;
        case (funct3_q[1:0])
            2'd0: ld_ext = {{(XLEN-8){ld_shifted[7] & ~funct3_q[2]}}, ld_shifted[7:0]};
            2'd1: ld_ext = {{(XLEN-16){ld_shifted[15] & ~funct3_q[2]}}, ld_shifted[15:0]};
            2'd2: ld_ext = {{(XLEN-32){ld_shifted[31] & ~funct3_q[2]}}, ld_shifted[31:0]};
            default: ld_ext = ld_shifted;
        endcase
    end

    // Outputs are computed for the state being entered so every port comes straight off a flop.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_load_d    = is_load_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        rd_d         = rd_q;
        ren_d        = 1'b0;
        raddr_d      = '0;
        wen_d        = 1'b0;
        waddr_d      = '0;
        wdata_d      = '0;
        mask_d       = 8'h00;
        resp_valid_d = 1'b0;
        resp_rd_d    = 5'd0;
        resp_data_d  = '0;
        fault_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && ready_q && (req_is_load_i || req_is_store_i)) begin
                    is_load_d = acc_load;
                    funct3_d  = funct3_i;
                    off_d     = addr_i[2:0];
                    rd_d      = rd_i;
                    if (acc_fault) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        fault_d      = 1'b1;
                    end else if (acc_load) begin
                        state_d = S_REQ;
                        ren_d   = 1'b1;
                        raddr_d = {addr_i[XLEN-1:3], 3'b000};
                    end else begin
                        state_d = S_REQ;
                        wen_d   = 1'b1;
                        waddr_d = {addr_i[XLEN-1:3], 3'b000};
                        wdata_d = wdata_i << {addr_i[2:0], 3'b000};
                        mask_d  = acc_size_mask << addr_i[2:0];
                    end
                end
            end
            S_REQ: begin
                if (is_load_q) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rd_d    = rd_q;
                    resp_data_d  = ld_ext;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        hold_d  = (state_d == S_REQ) || (state_d == S_WAIT);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            is_load_q    <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 3'd0;
            rd_q         <= 5'd0;
            ready_q      <= 1'b1;
            ren_q        <= 1'b0;
            raddr_q      <= '0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            mask_q       <= 8'h00;
            resp_valid_q <= 1'b0;
            resp_rd_q    <= 5'd0;
            resp_data_q  <= '0;
            fault_q      <= 1'b0;
            hold_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_load_q    <= is_load_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            ready_q      <= ready_d;
            ren_q        <= ren_d;
            raddr_q      <= raddr_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            resp_valid_q <= resp_valid_d;
            resp_rd_q    <= resp_rd_d;
            resp_data_q  <= resp_data_d;
            fault_q      <= fault_d;
            hold_q       <= hold_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign mem_ren_o    = ren_q;
    assign mem_raddr_o  = raddr_q;
    assign mem_wen_o    = wen_q;
    assign mem_waddr_o  = waddr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_mask_o   = mask_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rd_o    = resp_rd_q;
    assign resp_data_o  = resp_data_q;
    assign fault_o      = fault_q;
    assign hold_flag_o  = hold_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu with MEM_LAT=1 and MEM_LAT=3 instances
module tb_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        lo = 1'b0, st = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [63:0] addr = 64'd0, wd = 64'd0;
    logic [4:0]  rd = 5'd0;

    logic        v1, v3;
    logic        a_ready, a_ren, a_wen, a_rv, a_fault, a_hold;
    logic [63:0] a_raddr, a_waddr, a_wdata, a_rdata, a_mrd;
    logic [7:0]  a_mask;
    logic [4:0]  a_rrd;
    logic        b_ready, b_ren, b_wen, b_rv, b_fault, b_hold;
    logic [63:0] b_raddr, b_waddr, b_wdata, b_rdata, b_mrd;
    logic [7:0]  b_mask;
    logic [4:0]  b_rrd;

    assign v1 = req_valid & ~sel;
    assign v3 = req_valid & sel;

    lsu #(.XLEN(64), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid_i(v1), .req_ready_o(a_ready),
        .req_is_load_i(lo), .req_is_store_i(st), .funct3_i(f3), .addr_i(addr),
        .wdata_i(wd), .rd_i(rd), .mem_ren_o(a_ren), .mem_raddr_o(a_raddr),
        .mem_rdata_i(a_mrd), .mem_wen_o(a_wen), .mem_waddr_o(a_waddr),
        .mem_wdata_o(a_wdata), .mem_mask_o(a_mask), .resp_valid_o(a_rv),
        .resp_rd_o(a_rrd), .resp_data_o(a_rdata), .fault_o(a_fault), .hold_flag_o(a_hold)
    );

    lsu #(.XLEN(64), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid_i(v3), .req_ready_o(b_ready),
        .req_is_load_i(lo), .req_is_store_i(st), .funct3_i(f3), .addr_i(addr),
        .wdata_i(wd), .rd_i(rd), .mem_ren_o(b_ren), .mem_raddr_o(b_raddr),
        .mem_rdata_i(b_mrd), .mem_wen_o(b_wen), .mem_waddr_o(b_waddr),
        .mem_wdata_o(b_wdata), .mem_mask_o(b_mask), .resp_valid_o(b_rv),
        .resp_rd_o(b_rrd), .resp_data_o(b_rdata), .fault_o(b_fault), .hold_flag_o(b_hold)
    );

    logic        o_ready, o_ren, o_wen, o_rv, o_fault, o_hold;
    logic [63:0] o_raddr, o_waddr, o_wdata, o_rdata;
    logic [7:0]  o_mask;
    logic [4:0]  o_rrd;
    assign o_ready = sel ? b_ready : a_ready;
    assign o_ren   = sel ? b_ren   : a_ren;
    assign o_wen   = sel ? b_wen   : a_wen;
    assign o_rv    = sel ? b_rv    : a_rv;
    assign o_fault = sel ? b_fault : a_fault;
    assign o_hold  = sel ? b_hold  : a_hold;
    assign o_raddr = sel ? b_raddr : a_raddr;
    assign o_waddr = sel ? b_waddr : a_waddr;
    assign o_wdata = sel ? b_wdata : a_wdata;
    assign o_rdata = sel ? b_rdata : a_rdata;
    assign o_mask  = sel ? b_mask  : a_mask;
    assign o_rrd   = sel ? b_rrd   : a_rrd;

    function automatic logic [63:0] memword(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h8899AABBCCDDEEFF;
        if (a == 64'h8000_0008) return 64'h0123456789ABCDEF;
        return {a[31:0] ^ 32'hA5C396E1, a[31:0] * 32'd2654435761};
    endfunction

    // Memory returns real data only in the cycle its latency says it is valid.
    logic [3:0]  age1 = 4'd0, age3 = 4'd0;
    logic [63:0] la1 = 64'd0, la3 = 64'd0;
    always @(posedge clk) begin
        if (a_ren) begin age1 <= 4'd1; la1 <= a_raddr; end
        else if (age1 != 4'd0 && age1 != 4'd15) age1 <= age1 + 4'd1;
        if (b_ren) begin age3 <= 4'd1; la3 <= b_raddr; end
        else if (age3 != 4'd0 && age3 != 4'd15) age3 <= age3 + 4'd1;
    end
    assign a_mrd = (age1 == 4'd1) ? memword(la1) : 64'hBAD0_BAD0_BAD0_BAD0;
    assign b_mrd = (age3 == 4'd3) ? memword(la3) : 64'hBAD0_BAD0_BAD0_BAD0;

    typedef struct {
        int ren_n; int ren_cyc; logic [63:0] raddr;
        int wen_n; int wen_cyc; logic [63:0] waddr; logic [63:0] wdata; logic [7:0] mask;
        int hold_n; int busy_n; int resp_cyc; int stray;
        logic [63:0] data; logic [4:0] rd; logic fault; logic after_ok;
    } obs_t;

    typedef struct {
        logic fault; int lat; int ren_n; logic [63:0] raddr;
        int wen_n; logic [63:0] waddr; logic [63:0] wdata; logic [7:0] mask;
        int hold_n; logic [63:0] data; logic [4:0] rd;
    } exp_t;

    typedef struct {
        logic s; logic l; logic t; logic [2:0] f; logic [63:0] a; logic [63:0] w; logic [4:0] r;
        logic [63:0] x_data; logic x_fault; int x_lat;
    } vec_t;

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic s, input logic l, input logic t, input logic [2:0] f,
                                   input logic [63:0] a, input logic [63:0] w, input logic [4:0] r);
        exp_t e;
        int nb, off, lat_mem;
        logic ill, mis;
        logic [63:0] word, val;
        e = '{default: 0};
        nb = 1 << f[1:0];
        off = int'(a[2:0]);
        lat_mem = s ? 3 : 1;
        ill = l ? (f == 3'd7) : (f > 3'd3);
        mis = (off % nb) != 0;
        if (ill || mis) begin
            e.fault = 1'b1;
            e.lat = 1;
            return e;
        end
        if (l) begin
            e.ren_n = 1;
            e.raddr = a - 64'(off);
            word = memword(e.raddr);
            val = 64'd0;
            for (int i = 0; i < nb; i++) val[8*i +: 8] = word[8*(off+i) +: 8];
            if (!f[2] && nb < 8 && val[8*nb-1]) val = val | (~64'd0 << (8*nb));
            e.data = val;
            e.rd = r;
            e.lat = 2 + lat_mem;
            e.hold_n = 1 + lat_mem;
        end else begin
            e.wen_n = 1;
            e.waddr = a - 64'(off);
            e.wdata = w << (8*off);
            for (int i = 0; i < nb; i++) e.mask[off+i] = 1'b1;
            e.lat = 2;
            e.hold_n = 1;
        end
        return e;
    endfunction

    task automatic run_req(input logic s, input logic l, input logic t, input logic [2:0] f,
                           input logic [63:0] a, input logic [63:0] w, input logic [4:0] r,
                           output obs_t o);
        o = '{default: 0};
        o.resp_cyc = -1;
        sel = s; lo = l; st = t; f3 = f; addr = a; wd = w; rd = r;
        req_valid = 1'b1;
        #1;
        check("ready_idle", 64'(o_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lo = 1'($urandom); st = 1'($urandom); f3 = 3'($urandom);
        addr = {$urandom, $urandom}; wd = {$urandom, $urandom}; rd = 5'($urandom);
        for (int k = 1; k <= 30; k++) begin
            if (o_ren) begin o.ren_n++; o.ren_cyc = k; o.raddr = o_raddr; end
            else if (o_raddr != 64'd0) o.stray++;
            if (o_wen) begin o.wen_n++; o.wen_cyc = k; o.waddr = o_waddr; o.wdata = o_wdata; o.mask = o_mask; end
            else if ((o_waddr | o_wdata) != 64'd0 || o_mask != 8'd0) o.stray++;
            if (o_hold) o.hold_n++;
            if (!o_ready) o.busy_n++;
            if (o_rv) begin
                o.resp_cyc = k; o.data = o_rdata; o.rd = o_rrd; o.fault = o_fault;
                break;
            end else if (o_rdata != 64'd0 || o_rrd != 5'd0 || o_fault) o.stray++;
            @(posedge clk); #1;
        end
        if (o.resp_cyc > 0) begin
            @(posedge clk); #1;
            o.after_ok = o_ready && !o_rv && !o_hold;
        end
    endtask

    task automatic compare_tx(input string tag, input exp_t e, input obs_t o);
        check({tag, ".lat"},   64'(o.resp_cyc), 64'(e.lat));
        check({tag, ".fault"}, 64'(o.fault), 64'(e.fault));
        check({tag, ".ren_n"}, 64'(o.ren_n), 64'(e.ren_n));
        check({tag, ".raddr"}, o.raddr, e.raddr);
        check({tag, ".wen_n"}, 64'(o.wen_n), 64'(e.wen_n));
        check({tag, ".waddr"}, o.waddr, e.waddr);
        check({tag, ".wdata"}, o.wdata, e.wdata);
        check({tag, ".mask"},  64'(o.mask), 64'(e.mask));
        check({tag, ".hold"},  64'(o.hold_n), 64'(e.hold_n));
        check({tag, ".busy"},  64'(o.busy_n), 64'(e.lat));
        check({tag, ".data"},  o.data, e.data);
        check({tag, ".rd"},    64'(o.rd), 64'(e.rd));
        check({tag, ".stray"}, 64'(o.stray), 64'd0);
        check({tag, ".idle_after"}, 64'(o.after_ok), 64'd1);
        if (e.ren_n == 1) check({tag, ".ren_cyc"}, 64'(o.ren_cyc), 64'd1);
        if (e.wen_n == 1) check({tag, ".wen_cyc"}, 64'(o.wen_cyc), 64'd1);
    endtask

    vec_t tbl[12];
    obs_t ob;
    exp_t ex;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 3'b000, 64'h8000_0003, 64'd0, 5'd5, 64'hFFFF_FFFF_FFFF_FFCC, 1'b0, 3};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 3'b100, 64'h8000_0003, 64'd0, 5'd6, 64'h0000_0000_0000_00CC, 1'b0, 3};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'hBEEF, 5'd7, 64'd0, 1'b0, 2};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'd0, 5'd8, 64'd0, 1'b1, 1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 3'b011, 64'h8000_0008, 64'd0, 5'd9, 64'h0123456789ABCDEF, 1'b0, 5};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 3'b111, 64'h8000_0000, 64'd0, 5'd10, 64'd0, 1'b1, 1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 3'b001, 64'h8000_0002, 64'd0, 5'd11, 64'hFFFF_FFFF_FFFF_CCDD, 1'b0, 3};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 3'b110, 64'h8000_0004, 64'd0, 5'd12, 64'h0000_0000_8899_AABB, 1'b0, 3};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 3'b010, 64'h8000_0004, 64'd0, 5'd13, 64'hFFFF_FFFF_8899_AABB, 1'b0, 3};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 3'b011, 64'h8000_0007, 64'h55, 5'd14, 64'd0, 1'b1, 1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 3'b100, 64'h8000_0000, 64'h55, 5'd15, 64'd0, 1'b1, 1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 3'b000, 64'h8000_0009, 64'h77, 5'd16, 64'hFFFF_FFFF_FFFF_FFCD, 1'b0, 5};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {62'd0, a_ready, b_ready}, 64'd3);
        check("rst_outs", 64'({a_ren, a_wen, a_rv, a_fault, a_hold, b_ren, b_wen, b_rv, b_fault, b_hold}), 64'd0);
        check("rst_buses", a_raddr | a_waddr | a_wdata | a_rdata | b_raddr | b_waddr | b_wdata | b_rdata
                           | 64'(a_mask) | 64'(b_mask) | 64'(a_rrd) | 64'(b_rrd), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_req(tbl[i].s, tbl[i].l, tbl[i].t, tbl[i].f, tbl[i].a, tbl[i].w, tbl[i].r, ob);
            check($sformatf("tbl%0d.data", i), ob.data, tbl[i].x_data);
            check($sformatf("tbl%0d.fault", i), 64'(ob.fault), 64'(tbl[i].x_fault));
            check($sformatf("tbl%0d.lat", i), 64'(ob.resp_cyc), 64'(tbl[i].x_lat));
            ex = model(tbl[i].s, tbl[i].l, tbl[i].t, tbl[i].f, tbl[i].a, tbl[i].w, tbl[i].r);
            compare_tx($sformatf("tbl%0d", i), ex, ob);
        end

        // Neither load nor store: must never be accepted.
        sel = 1'b0; lo = 1'b0; st = 1'b0; f3 = 3'd3; addr = 64'h8000_0000; req_valid = 1'b1;
        begin
            int busy;
            busy = 0;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                if (!a_ready || a_hold || a_ren || a_wen || a_rv) busy++;
            end
            check("no_op_ignored", 64'(busy), 64'd0);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;

        // req_valid held high: load then store, store accepted in the IDLE cycle after load RESP.
        begin
            int r1, r2, wc, wn;
            logic [63:0] d1, wa, wdat;
            logic [7:0] wm;
            r1 = -1; r2 = -1; wc = -1; wn = 0; d1 = 0; wa = 0; wdat = 0; wm = 0;
            sel = 1'b0; lo = 1'b1; st = 1'b0; f3 = 3'b000; addr = 64'h8000_0003; rd = 5'd3;
            req_valid = 1'b1;
            @(posedge clk); #1;
            lo = 1'b0; st = 1'b1; f3 = 3'b011; addr = 64'h8000_0010; wd = 64'h1122334455667788;
            for (int k = 1; k <= 12; k++) begin
                if (a_wen) begin wn++; wc = k; wa = a_waddr; wdat = a_wdata; wm = a_mask; req_valid = 1'b0; end
                if (a_rv && r1 < 0) begin r1 = k; d1 = a_rdata; end
                else if (a_rv && r2 < 0) r2 = k;
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
            check("b2b.load_resp", 64'(r1), 64'd3);
            check("b2b.load_data", d1, 64'hFFFF_FFFF_FFFF_FFCC);
            check("b2b.wen_cyc", 64'(wc), 64'd5);
            check("b2b.wen_n", 64'(wn), 64'd1);
            check("b2b.waddr", wa, 64'h8000_0010);
            check("b2b.wdata", wdat, 64'h1122334455667788);
            check("b2b.mask", 64'(wm), 64'hFF);
            check("b2b.store_resp", 64'(r2), 64'd6);
        end

        // Asynchronous reset in the middle of a MEM_LAT=3 load.
        sel = 1'b1; lo = 1'b1; st = 1'b0; f3 = 3'b011; addr = 64'h8000_0008; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rstw.in_wait", 64'(b_hold), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rstw.ready", 64'(b_ready), 64'd1);
        check("rstw.outs", 64'({b_ren, b_wen, b_rv, b_fault, b_hold}), 64'd0);
        check("rstw.buses", b_raddr | b_waddr | b_wdata | b_rdata | 64'(b_mask) | 64'(b_rrd), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            int rv_seen;
            rv_seen = 0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk); #1;
                if (b_rv || b_hold) rv_seen++;
            end
            check("rstw.no_resp", 64'(rv_seen), 64'd0);
        end

        for (int i = 0; i < 60; i++) begin
            logic s, l, t;
            logic [2:0] f;
            logic [63:0] a, w;
            logic [4:0] r;
            s = 1'($urandom);
            l = 1'($urandom);
            t = l ? 1'($urandom) : 1'b1;
            f = 3'($urandom);
            a = (i % 3 == 0) ? (64'h8000_0000 | 64'($urandom_range(0, 15))) : {$urandom, $urandom};
            w = {$urandom, $urandom};
            r = 5'($urandom);
            run_req(s, l, t, f, a, w, r, ob);
            ex = model(s, l, t, f, a, w, r);
            compare_tx($sformatf("rnd%0d", i), ex, ob);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
